tft_pix_win: RTL and testbench

Parametrised pixel source for the TFT path of the ETC2 decoder. It places the decoded image in a window whose position is set at run time, and generates read addresses for the decoded-pixel buffer so that buffer read latency is absorbed. It selects between image data and one of four background patterns. It sits between the TFT timing generator (which supplies pix_x/pix_y) and the RGB565 output stage. Display starts only on a frame boundary, and the window position is latched per frame, so switching never tears an image.

---
 rtl/tft_pix_win.sv | 141 ++++++++++++++
 tb/tb_tft_pix_win.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_pix_win.sv
// Windowed pixel source for the TFT path: places the decoded image at a
// per-frame latched position, issues buffer reads ahead of the pixel,
// and fills the rest of the screen with a selectable background pattern.
module tft_pix_win #(
  parameter int unsigned H_VALID = 800,
  parameter int unsigned V_VALID = 480,
  parameter int unsigned IMG_W   = 128,
  parameter int unsigned IMG_H   = 128,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic              tft_sclk_33m,
  input  logic              srst,
  input  logic [10:0]       pix_x,
  input  logic [10:0]       pix_y,
  input  logic              decode_finished,
  input  logic [10:0]       win_x0,
  input  logic [10:0]       win_y0,
  input  logic [1:0]        bg_mode,
  input  logic [15:0]       etc_rgb,
  output logic              rd_en,
  output logic [ADDR_W-1:0] address,
  output logic [15:0]       pix_data,
  output logic              frame_done
);

  localparam int unsigned XW   = $clog2(IMG_W);
  localparam int unsigned BAND = H_VALID / 10;

  localparam logic [15:0] BAR [10] = '{
    16'hF800, 16'hFC00, 16'hFFE0, 16'h07E0, 16'h07FF,
    16'h001F, 16'hF81F, 16'h0000, 16'hFFFF, 16'hD69A
  };

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StShow
  } state_e;

  state_e      state, state_next;
  logic [10:0] lx0, ly0;

  logic        at_origin;
  logic        show_ok;
  logic        hit;
  logic [11:0] x12, y12, lx12, ly12;
  logic [10:0] dx, dy;
  logic [31:0] addr_full;
  logic [15:0] bar_col;
  logic [15:0] bg_col;

  // Delay line aligning hit/background with buffer read data.
  logic [RD_LAT:0] hit_pipe;
  logic [15:0]     bg_pipe [RD_LAT+1];

  assign at_origin = (pix_x == 11'd0) && (pix_y == 11'd0);

  // Next state: decode_finished low overrides everything.
  always_comb begin
    state_next = state;
    if (!decode_finished) begin
      state_next = StIdle;
    end else begin
      unique case (state)
        StIdle:  state_next = StArmed;
        StArmed: if (at_origin) state_next = StShow;
        StShow:  state_next = StShow;
        default: state_next = StIdle;
      endcase
    end
  end

  // Window hit test in 12 bits so lx0+IMG_W cannot wrap; off-screen parts are clipped.
  always_comb begin
    show_ok = (state == StShow) && (state_next != StIdle);
    x12     = {1'b0, pix_x};
    y12     = {1'b0, pix_y};
    lx12    = {1'b0, lx0};
    ly12    = {1'b0, ly0};
    hit     = show_ok
              && (pix_x < 11'(H_VALID)) && (pix_y < 11'(V_VALID))
              && (x12 >= lx12) && (x12 < lx12 + 12'(IMG_W))
              && (y12 >= ly12) && (y12 < ly12 + 12'(IMG_H));
    dx        = pix_x - lx0;
    dy        = pix_y - ly0;
    // IMG_W is a power of two, so row*IMG_W+col is a shift and concatenation.
    addr_full = (32'(dy) << XW) | 32'(dx[XW-1:0]);
  end

  // Background pattern, forced black unless an image frame is being shown.
  always_comb begin
    bar_col = BAR[0];
    for (int unsigned k = 1; k < 10; k++) begin
      if (32'(pix_x) >= k * BAND) bar_col = BAR[k];
    end
    if (32'(pix_x) >= H_VALID) bar_col = 16'h0000;

    bg_col = 16'h0000;
    if (show_ok) begin
      unique case (bg_mode)
        2'd1:    bg_col = bar_col;
        2'd2:    bg_col = 16'hD69A;
        2'd3:    bg_col = (pix_x[3] ^ pix_y[3]) ? 16'hFFFF : 16'h0000;
        default: bg_col = 16'h0000;
      endcase
    end
  end

  // State, window latch, read strobe/address, delay line and outputs.
  always_ff @(posedge tft_sclk_33m) begin
    if (!srst) begin
      state      <= StIdle;
      lx0        <= '0;
      ly0        <= '0;
      rd_en      <= 1'b0;
      address    <= '0;
      hit_pipe   <= '0;
      for (int unsigned k = 0; k <= RD_LAT; k++) bg_pipe[k] <= '0;
      pix_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == StShow && at_origin) begin
        lx0 <= win_x0;
        ly0 <= win_y0;
      end

      rd_en <= hit;
      if (hit) address <= addr_full[ADDR_W-1:0];

      hit_pipe   <= {hit_pipe[RD_LAT-1:0], hit};
      bg_pipe[0] <= bg_col;
      for (int unsigned k = 1; k <= RD_LAT; k++) bg_pipe[k] <= bg_pipe[k-1];

      pix_data   <= hit_pipe[RD_LAT] ? etc_rgb : bg_pipe[RD_LAT];
      frame_done <= show_ok && (pix_x == 11'(H_VALID - 1)) && (pix_y == 11'(V_VALID - 1));
    end
  end

endmodule

// File: tb/tb_tft_pix_win.sv
// Bench for tft_pix_win: a frame-level reference model predicts strobes,
// addresses, pixels and frame pulses for arbitrary coordinate sequences.
module tb_tft_pix_win;

  localparam int H  = 800;
  localparam int V  = 480;
  localparam int IW = 128;
  localparam int IH = 128;
  localparam int AW = 16;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          srst = 1'b0;
  logic [10:0]   pix_x = '0, pix_y = '0;
  logic          decode_finished = 1'b0;
  logic [10:0]   win_x0 = '0, win_y0 = '0;
  logic [1:0]    bg_mode = '0;
  logic [15:0]   etc_rgb = '0;
  logic          rd_en;
  logic [AW-1:0] address;
  logic [15:0]   pix_data;
  logic          frame_done;

  int total = 0;
  int bad   = 0;

  tft_pix_win #(
    .H_VALID(H), .V_VALID(V), .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW), .RD_LAT(RL)
  ) dut (
    .tft_sclk_33m   (clk),
    .srst           (srst),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .decode_finished(decode_finished),
    .win_x0         (win_x0),
    .win_y0         (win_y0),
    .bg_mode        (bg_mode),
    .etc_rgb        (etc_rgb),
    .rd_en          (rd_en),
    .address        (address),
    .pix_data       (pix_data),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  // Image content stored in the decoded-pixel buffer.
  function automatic logic [15:0] img(input logic [15:0] a);
    return 16'((32'(a) * 40503) ^ 32'h1234);
  endfunction

  // Buffer with one edge of read latency.
  always @(posedge clk) etc_rgb <= img(address);

  function automatic logic [15:0] bg_ref(input logic [1:0] m, input int x, input int y);
    logic [15:0] bars [10];
    bars = '{16'hF800, 16'hFC00, 16'hFFE0, 16'h07E0, 16'h07FF,
             16'h001F, 16'hF81F, 16'h0000, 16'hFFFF, 16'hD69A};
    case (m)
      2'd1:    return (x >= H) ? 16'h0000 : bars[x / (H / 10)];
      2'd2:    return 16'hD69A;
      2'd3:    return (((x / 8) + (y / 8)) % 2 == 1) ? 16'hFFFF : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  // Reference model: 0 waiting for image, 1 waiting for frame start, 2 showing.
  int          m_mode = 0;
  int          m_lx = 0, m_ly = 0;
  logic        e_rd = 1'b0, e_fd = 1'b0;
  logic [15:0] e_addr = '0, e_pix = '0;
  logic [15:0] pq[$] = '{16'h0, 16'h0};

  // Apply one coordinate, advance the model, and wait past the edge.
  task automatic cyc(input int x, input int y);
    logic        showing, hit;
    logic [15:0] nv;
    pix_x = 11'(x);
    pix_y = 11'(y);
    if (!srst) begin
      m_mode = 0; m_lx = 0; m_ly = 0;
      e_rd = 1'b0; e_addr = '0; e_pix = '0; e_fd = 1'b0;
      pq = '{16'h0, 16'h0};
    end else begin
      showing = decode_finished && m_mode == 2;
      hit = showing && x < H && y < V && x >= m_lx && x < m_lx + IW
            && y >= m_ly && y < m_ly + IH;
      e_rd = hit;
      if (hit) e_addr = 16'((y - m_ly) * IW + (x - m_lx));
      nv = hit ? img(e_addr) : (showing ? bg_ref(bg_mode, x, y) : 16'h0000);
      e_pix = pq.pop_front();
      pq.push_back(nv);
      e_fd = showing && x == H - 1 && y == V - 1;
      if (!decode_finished) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else if (x == 0 && y == 0) begin
        m_mode = 2; m_lx = int'(win_x0); m_ly = int'(win_y0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int wx, input int wy);
    decode_finished = 1'b1;
    win_x0 = 11'(wx);
    win_y0 = 11'(wy);
    cyc(5, 5);
    cyc(0, 0);
  endtask

  task automatic test_reset;
    srst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      decode_finished = 1'($urandom);
      bg_mode = 2'($urandom);
      win_x0 = 11'($urandom);
      cyc($urandom_range(0, 900), $urandom_range(0, 500));
      total++;
      if ({rd_en, address, pix_data, frame_done} !== '0) begin
        bad++;
        $display("FAIL reset: rd_en=%b addr=%h pix=%h fd=%b want all 0",
                 rd_en, address, pix_data, frame_done);
      end
    end
    srst = 1'b1;
    decode_finished = 1'b1;
    win_x0 = '0; win_y0 = '0;
    cyc(0, 0);   // leaves idle, must not start showing on this origin
    cyc(10, 10);
    total++;
    if (rd_en !== 1'b0 || rd_en !== e_rd) begin
      bad++;
      $display("FAIL reset_origin_armed: rd_en=%b want 0", rd_en);
    end
  endtask

  task automatic test_image;
    int strobes = 0;
    start_frame(336, 176);
    for (int y = 176; y < 176 + IH; y++) begin
      for (int x = 330; x <= 470; x++) begin
        bg_mode = 2'($urandom);
        win_x0 = 11'($urandom);  // mid-frame changes must be ignored
        win_y0 = 11'($urandom);
        cyc(x, y);
        if (rd_en === 1'b1) strobes++;
        total++;
        if ({rd_en, address, pix_data, frame_done} !== {e_rd, e_addr, e_pix, e_fd}) begin
          bad++;
          $display("FAIL image(%0d,%0d): rd=%b a=%h p=%h fd=%b want rd=%b a=%h p=%h fd=%b",
                   x, y, rd_en, address, pix_data, frame_done, e_rd, e_addr, e_pix, e_fd);
        end
        if ((x == 336 && y == 176) || (x == 463 && y == 176) || (x == 336 && y == 177)) begin
          total++;
          if (rd_en !== 1'b1 || address !== ((x == 463) ? 16'd127 : (y == 177) ? 16'd128 : 16'd0)) begin
            bad++;
            $display("FAIL image_addr(%0d,%0d): rd=%b addr=%0d", x, y, rd_en, address);
          end
        end
      end
    end
    total++;
    if (strobes !== IW * IH) begin
      bad++;
      $display("FAIL image_strobes: got %0d want %0d", strobes, IW * IH);
    end
    cyc(799, 479);
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL image_frame_done: got %b want 1", frame_done);
    end
  endtask

  task automatic test_background;
    logic [15:0] want [4];
    start_frame(600, 300);
    bg_mode = 2'd1;
    cyc(79, 10);
    cyc(80, 10);
    cyc(799, 10);
    want[0] = pix_data;
    cyc(10, 10);
    want[1] = pix_data;
    cyc(10, 10);
    want[2] = pix_data;
    bg_mode = 2'd3;
    cyc(8, 0);
    cyc(1, 1);
    cyc(1, 1);
    want[3] = pix_data;
    total += 4;
    if (want[0] !== 16'hF800) begin bad++; $display("FAIL bars_x79: got %h want F800", want[0]); end
    if (want[1] !== 16'hFC00) begin bad++; $display("FAIL bars_x80: got %h want FC00", want[1]); end
    if (want[2] !== 16'hD69A) begin bad++; $display("FAIL bars_x799: got %h want D69A", want[2]); end
    if (want[3] !== 16'hFFFF) begin bad++; $display("FAIL checker_8_0: got %h want FFFF", want[3]); end
    for (int i = 0; i < 400; i++) begin
      bg_mode = 2'($urandom);
      cyc($urandom_range(0, 820), $urandom_range(1, 490));
      total++;
      if ({rd_en, address, pix_data, frame_done} !== {e_rd, e_addr, e_pix, e_fd}) begin
        bad++;
        $display("FAIL bg_random(%0d,%0d): rd=%b a=%h p=%h want rd=%b a=%h p=%h",
                 pix_x, pix_y, rd_en, address, pix_data, e_rd, e_addr, e_pix);
      end
    end
  endtask

  task automatic test_clip;
    int strobes = 0;
    start_frame(750, 400);
    for (int y = 400; y <= 485; y++) begin
      for (int x = 745; x <= 805; x++) begin
        bg_mode = 2'($urandom);
        cyc(x, y);
        if (rd_en === 1'b1) strobes++;
        total++;
        if ({rd_en, address, pix_data, frame_done} !== {e_rd, e_addr, e_pix, e_fd}) begin
          bad++;
          $display("FAIL clip(%0d,%0d): rd=%b a=%h p=%h fd=%b want rd=%b a=%h p=%h fd=%b",
                   x, y, rd_en, address, pix_data, frame_done, e_rd, e_addr, e_pix, e_fd);
        end
        if ((x == 799 && y == 400) || (x == 750 && y == 401)) begin
          total++;
          if (rd_en !== 1'b1 || address !== ((x == 799) ? 16'd49 : 16'd128)) begin
            bad++;
            $display("FAIL clip_addr(%0d,%0d): rd=%b addr=%0d", x, y, rd_en, address);
          end
        end
      end
    end
    total++;
    if (strobes !== 50 * 80) begin
      bad++;
      $display("FAIL clip_strobes: got %0d want %0d", strobes, 50 * 80);
    end
  endtask

  task automatic test_drop;
    int strobes = 0;
    start_frame(336, 176);
    for (int x = 390; x < 400; x++) cyc(x, 200);
    decode_finished = 1'b0;
    cyc(400, 200);
    total++;
    if (rd_en !== 1'b0 || rd_en !== e_rd) begin
      bad++;
      $display("FAIL drop_rd_en: got %b want 0", rd_en);
    end
    cyc(401, 200);
    cyc(402, 200);
    total++;
    if (pix_data !== 16'h0000 || pix_data !== e_pix) begin
      bad++;
      $display("FAIL drop_pix: got %h want 0000", pix_data);
    end
    decode_finished = 1'b1;
    for (int y = 200; y <= 202; y++) begin
      for (int x = 330; x <= 470; x++) begin
        cyc(x, y);
        if (rd_en === 1'b1) strobes++;
        total++;
        if ({rd_en, address, pix_data} !== {e_rd, e_addr, e_pix}) begin
          bad++;
          $display("FAIL drop_rearm(%0d,%0d): rd=%b a=%h p=%h want rd=%b a=%h p=%h",
                   x, y, rd_en, address, pix_data, e_rd, e_addr, e_pix);
        end
      end
    end
    total++;
    if (strobes !== 0) begin
      bad++;
      $display("FAIL drop_strobes: got %0d want 0", strobes);
    end
    cyc(0, 0);
    cyc(336, 176);
    total++;
    if (rd_en !== 1'b1 || address !== 16'd0) begin
      bad++;
      $display("FAIL drop_resume: rd=%b addr=%0d want rd=1 addr=0", rd_en, address);
    end
  endtask

  task automatic test_back_to_back;
    start_frame(336, 176);
    win_x0 = 11'd100;
    win_y0 = 11'd50;
    cyc(100, 50);
    total++;
    if (rd_en !== 1'b0 || rd_en !== e_rd) begin
      bad++; $display("FAIL win_old_frame_new_pos: rd=%b want 0", rd_en);
    end
    cyc(336, 176);
    total++;
    if (rd_en !== 1'b1 || address !== 16'd0) begin
      bad++; $display("FAIL win_old_frame_old_pos: rd=%b addr=%0d want 1/0", rd_en, address);
    end
    cyc(799, 479);
    total++;
    if (frame_done !== 1'b1 || frame_done !== e_fd) begin
      bad++; $display("FAIL frame_done_pulse: got %b want 1", frame_done);
    end
    cyc(0, 0);
    total++;
    if (frame_done !== 1'b0) begin
      bad++; $display("FAIL frame_done_width: got %b want 0", frame_done);
    end
    cyc(100, 50);
    total++;
    if (rd_en !== 1'b1 || address !== 16'd0) begin
      bad++; $display("FAIL win_new_frame_new_pos: rd=%b addr=%0d want 1/0", rd_en, address);
    end
    cyc(336, 176);
    total++;
    if (rd_en !== 1'b0 || rd_en !== e_rd) begin
      bad++; $display("FAIL win_new_frame_old_pos: rd=%b want 0", rd_en);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_image();
    test_background();
    test_clip();
    test_drop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
